// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arb_pkg;
  localparam int DATA_W = 16;
  localparam int N_REQ  = 4;
  localparam int PTR_W  = 2;
  // Pointer resets to the last index so requester 0 is scanned first.
  localparam logic [PTR_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter4_if.sv
// Requester/sink bundle for rr_arbiter4; slave is the arbiter side, master the environment.
interface rr_arbiter4_if #(parameter int DATA_W = rr_arb_pkg::DATA_W);
  logic [3:0]        req;
  logic [DATA_W-1:0] a, b, c, d;
  logic [3:0]        lock;
  logic [3:0]        ack;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        sel;

  modport slave (
    input  req, a, b, c, d, lock, out_ready,
    output ack, out_data, out_valid, sel
  );

  modport master (
    output req, a, b, c, d, lock, out_ready,
    input  ack, out_data, out_valid, sel
  );
endinterface

// File: rtl/rr_arbiter4_pick.sv
// Combinational rotating-priority picker: first requester after ptr, wrapping back to ptr itself.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  logic [PTR_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = PTR_W'(ptr + PTR_W'(k));
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a one-entry output register and valid/ready sink.
// Define RR_ARB_LOCK_EN to let a winner holding lock keep the grant on its next beat.
module rr_arbiter4
  import rr_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);
  state_t                       state;
  logic [PTR_W-1:0]             ptr, sel_q, pick_idx, win_idx;
  logic                         pick_vld, load;
  logic [DATA_W-1:0]            data_q;
  logic [N_REQ-1:0][DATA_W-1:0] din;

  assign din = {bus.d, bus.c, bus.b, bus.a};

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

`ifdef RR_ARB_LOCK_EN
  logic             lock_vld, lock_hit;
  logic [PTR_W-1:0] lock_idx;

  assign lock_hit = lock_vld && bus.req[lock_idx];
  assign win_idx  = lock_hit ? lock_idx : pick_idx;

  // Lock is re-armed by each load and dropped as soon as its owner stops requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (load) begin
      lock_vld <= bus.lock[win_idx];
      lock_idx <= win_idx;
    end else if (!lock_hit) begin
      lock_vld <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign win_idx     = pick_idx;
`endif

  // Reset suppresses the grant so nothing is acknowledged on a discarded cycle.
  assign load = pick_vld && !rst && (state == ST_EMPTY || bus.out_ready);

  assign bus.ack       = load ? (N_REQ'(1) << win_idx) : '0;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= PTR_RST;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            data_q <= din[win_idx];
            sel_q  <= win_idx;
            ptr    <= win_idx;
            state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (load) begin
            data_q <= din[win_idx];
            sel_q  <= win_idx;
            ptr    <= win_idx;
          end else if (bus.out_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed-vector bench for rr_arbiter4: reset, rotation, stall, skip, drop, reset mid-transfer, lock.
module tb_rr_arbiter4;
  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  rr_arbiter4_if #(.DATA_W(16)) bus ();

  rr_arbiter4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b0000; bus.lock = 4'b0000; bus.out_ready = 1'b0;
    bus.a = 16'h0; bus.b = 16'h0; bus.c = 16'h0; bus.d = 16'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    vecs++; if (bus.out_data !== 16'h0) begin errs++; $display("FAIL reset_data got %h want 0000", bus.out_data); end
    vecs++; if (bus.sel !== 2'd0) begin errs++; $display("FAIL reset_sel got %0d want 0", bus.sel); end
    vecs++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
  endtask

  task automatic test_single();
    bus.req = 4'b0001; bus.a = 16'h1234; bus.out_ready = 1'b1;
    #1;
    vecs++; if (bus.ack !== 4'b0001) begin errs++; $display("FAIL single_ack got %b want 0001", bus.ack); end
    tick();
    bus.req = 4'b0000;
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %0b want 1", bus.out_valid); end
    vecs++; if (bus.out_data !== 16'h1234) begin errs++; $display("FAIL single_data got %h want 1234", bus.out_data); end
    vecs++; if (bus.sel !== 2'd0) begin errs++; $display("FAIL single_sel got %0d want 0", bus.sel); end
    #1;
    vecs++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL idle_ack got %b want 0000", bus.ack); end
    tick();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL drain_valid got %0b want 0", bus.out_valid); end
    vecs++; if (bus.out_data !== 16'h1234) begin errs++; $display("FAIL drain_hold got %h want 1234", bus.out_data); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ack;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b1111; bus.out_ready = 1'b1;
    bus.a = 16'hA000; bus.b = 16'hA001; bus.c = 16'hA002; bus.d = 16'hA003;
    for (int i = 0; i < 5; i++) begin
      exp_ack = 4'b0001 << (i % 4);
      #1;
      vecs++; if (bus.ack !== exp_ack) begin errs++; $display("FAIL rr_ack[%0d] got %b want %b", i, bus.ack, exp_ack); end
      tick();
      vecs++; if (bus.sel !== 2'(i % 4)) begin errs++; $display("FAIL rr_sel[%0d] got %0d want %0d", i, bus.sel, i % 4); end
      vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL rr_valid[%0d] got %0b want 1", i, bus.out_valid); end
      vecs++; if (bus.out_data !== 16'hA000 + 16'(i % 4)) begin errs++; $display("FAIL rr_data[%0d] got %h want %h", i, bus.out_data, 16'hA000 + 16'(i % 4)); end
    end
  endtask

  task automatic test_stall();
    tick();
    vecs++; if (bus.out_data !== 16'hA001) begin errs++; $display("FAIL stall_pre got %h want a001", bus.out_data); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL stall_ack[%0d] got %b want 0000", i, bus.ack); end
      tick();
      vecs++; if (bus.out_data !== 16'hA001 || bus.sel !== 2'd1 || bus.out_valid !== 1'b1) begin
        errs++; $display("FAIL stall_hold[%0d] got %h/%0d/%0b want a001/1/1", i, bus.out_data, bus.sel, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vecs++; if (bus.ack !== 4'b0100) begin errs++; $display("FAIL stall_resume_ack got %b want 0100", bus.ack); end
    tick();
    vecs++; if (bus.sel !== 2'd2 || bus.out_data !== 16'hA002) begin errs++; $display("FAIL stall_resume got %0d/%h want 2/a002", bus.sel, bus.out_data); end
  endtask

  task automatic test_skip();
    logic [1:0] exp_sel [3] = '{2'd0, 2'd2, 2'd0};
    bus.req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (bus.ack !== (4'b0001 << exp_sel[i])) begin errs++; $display("FAIL skip_ack[%0d] got %b want %b", i, bus.ack, 4'b0001 << exp_sel[i]); end
      tick();
      vecs++; if (bus.sel !== exp_sel[i]) begin errs++; $display("FAIL skip_sel[%0d] got %0d want %0d", i, bus.sel, exp_sel[i]); end
    end
    bus.req = 4'b0000;
    tick();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL skip_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_drop();
    // ptr=0 here; grant 1, then a stalled requester 3 withdraws and must leave ptr at 1.
    bus.req = 4'b0010; tick();
    bus.req = 4'b1000; bus.out_ready = 1'b0;
    #1;
    vecs++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL drop_ack got %b want 0000", bus.ack); end
    tick();
    bus.req = 4'b0000; tick();
    bus.req = 4'b0101; bus.out_ready = 1'b1;
    #1;
    vecs++; if (bus.ack !== 4'b0100) begin errs++; $display("FAIL drop_next_ack got %b want 0100", bus.ack); end
    tick();
    vecs++; if (bus.sel !== 2'd2 || bus.out_data !== 16'hA002) begin errs++; $display("FAIL drop_next got %0d/%h want 2/a002", bus.sel, bus.out_data); end
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b1111; rst = 1'b1;
    #1;
    vecs++; if (bus.ack !== 4'b0000) begin errs++; $display("FAIL rst_ack got %b want 0000", bus.ack); end
    tick();
    vecs++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.sel !== 2'd0) begin
      errs++; $display("FAIL rst_mid got %0b/%h/%0d want 0/0000/0", bus.out_valid, bus.out_data, bus.sel);
    end
    rst = 1'b0;
    #1;
    vecs++; if (bus.ack !== 4'b0001) begin errs++; $display("FAIL rst_first_ack got %b want 0001", bus.ack); end
    tick();
    vecs++; if (bus.sel !== 2'd0) begin errs++; $display("FAIL rst_first_sel got %0d want 0", bus.sel); end
  endtask

  task automatic test_lock();
`ifdef RR_ARB_LOCK_EN
    logic [3:0] exp_ack [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [3:0] lk      [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
`else
    logic [3:0] exp_ack [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] lk      [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req = 4'b0011; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.lock = lk[i];
      #1;
      vecs++; if (bus.ack !== exp_ack[i]) begin errs++; $display("FAIL lock_ack[%0d] got %b want %b", i, bus.ack, exp_ack[i]); end
      tick();
    end
    bus.req = 4'b0000; bus.lock = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_skip();
    test_drop();
    test_reset_mid();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter and output register that shares one 16-bit downstream consumer (register-file write port, memory data bus) among four requesters. Selects one requester per cycle with a rotating priority pointer, captures the winner's data into an output register with a valid/ready handshake, and returns a one-hot acknowledge to the winner. Sits between the datapath sources and the shared sink, replacing static 4:1 selection with fair, flow-controlled sequencing.

## Interface
- DATA_W, 16, width of each data input and of out_data
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  req[i]: requester i holds valid data; level, held until ack[i]
- a, b, c, d  in  DATA_W each  data of requesters 0..3; stable while own req high
- lock  in  4  lock[i]: requester i keeps the grant for its next beat (used only with RR_ARB_LOCK_EN)
- ack  out  4  one-hot, combinational; ack[i]=1 means requester i's data is captured at this edge
- out_data  out  DATA_W  registered data of the granted requester
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data this cycle
- sel  out  2  registered index of requester whose data is in out_data

## Operation
- States: EMPTY (out_valid=0), FULL (out_valid=1).
- load = (req != 0) && (state==EMPTY || out_ready).
- Winner: first i with req[i]=1 scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr = last granted index.
- On load: out_data <= winner data, sel <= winner, ptr <= winner, ack[winner]=1, state <= FULL.
- FULL with out_ready=1 and req==0: state <= EMPTY; out_data/sel hold last value.
- FULL with out_ready=0: no load, ack=0, out_data/sel/ptr hold (no overwrite of pending data).
- Simultaneous drain and load in FULL: single-cycle handoff, out_valid stays 1, throughput one beat per cycle.
- ack is zero whenever load=0; at most one ack bit set.
- Requester dropping req before ack: no grant, no side effects.
- Reset values: out_valid=0, out_data=0, sel=0, ack=0, ptr=3 (requester 0 has highest priority after reset), state=EMPTY.
- rst mid-transfer: pending out_data discarded, no ack that cycle.

## Timing
- req to ack: 0 cycles (combinational, same cycle as load).
- req to out_valid: 1 cycle when EMPTY or being drained.
- Sustained throughput: 1 beat/cycle with out_ready held high.
- Fairness: with all four req high and out_ready high, grants cycle 0,1,2,3,0,...; worst-case wait 3 beats.
- ack must not depend combinationally on out_data; path is req/out_ready/state/ptr only.

## Configuration
- RR_ARB_LOCK_EN defined: on a load where lock[winner]=1, the next load grants the same index if its req is still high, bypassing rotation; lock is released when lock[winner]=0 at a load or req[winner] drops. ptr still updates to winner.
- Undefined: lock port present but ignored; pure round-robin.

## Structure
- Package rr_arb_pkg: state enum (ST_EMPTY, ST_FULL), N_REQ=4, PTR_W=2, reset constant PTR_RST=2'd3.
- Sub-module rr_pick4: combinational; inputs req[3:0], ptr[1:0]; outputs gnt_idx[1:0], gnt_vld. Top holds registers, handshake and lock logic.

## Test plan
- Reset, then req=4'b0001, a=16'h1234, out_ready=1 -> ack=4'b0001 same cycle; next cycle out_valid=1, out_data=16'h1234, sel=0.
- req=4'b1111 constant, a..d=16'hA000..16'hA003, out_ready=1 -> sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- FULL with out_data=16'hA001, out_ready=0 for 5 cycles, req=4'b1111 -> ack=0, out_data/sel stable; on out_ready=1 next grant is index 2.
- req=4'b0101 after last grant 2 -> grant 0 then 2 (index 1,3 skipped), ptr wraps correctly.
- rst asserted while out_valid=1 -> next cycle out_valid=0, out_data=0, sel=0; first post-reset grant with req=4'b1111 is 0.
- RR_ARB_LOCK_EN: req=4'b0011, lock=4'b0001 -> grants 0,0,0; lock cleared -> next grant 1.
